// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package regfile_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREGS  = 32;

    // Register index that is hard-wired to zero and never written.
    localparam int ZERO_REG = 0;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; after a grant the pointer favours the other requester.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        // Granting index 0 moves the pointer to 1 and vice versa.
        if (advance && (gnt != 2'b00)) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU (req0) and load (req1) writeback.
// Define REGFILE_CLEAR_EN to zero every register in a post-reset clear sequence.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = DEF_NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              init_busy
);

    if ((NREGS < 1) || (NREGS > (1 << ADDR_W))) begin : g_nregs_check
        $error("NREGS must lie in 1..2**ADDR_W");
    end

    logic              run;
    logic [1:0]        arb_req;
    logic [1:0]        gnt;
    logic              xfer;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;

`ifdef REGFILE_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_INIT: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_REG) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign init_busy = (state_q == ST_INIT);
    assign run       = (state_q == ST_RUN);
`else
    assign init_busy = 1'b0;
    assign run       = 1'b1;
`endif

    // No grants while in reset or clearing, so readies stay low there.
    assign arb_req = {req1_valid, req0_valid} & {2{run && !rst}};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (run),
        .gnt     (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign xfer       = |gnt;
    assign win_addr   = gnt[1] ? req1_addr : req0_addr;
    assign win_data   = gnt[1] ? req1_data : req0_data;

    always_comb begin
        we_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
`ifdef REGFILE_CLEAR_EN
        if (state_q == ST_INIT) begin
            we_d = 1'b1;
            wa_d = clr_cnt_q;
            wd_d = '0;
        end
`endif
        // Writes to the zero register are accepted but never reach the file.
        if (xfer && (win_addr != ADDR_W'(ZERO_REG))) begin
            we_d = 1'b1;
            wa_d = win_addr;
            wd_d = win_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
        end else begin
            we_q <= we_d;
            wa_q <= wa_d;
            wd_q <= wd_d;
        end
    end

    assign rf_we = we_q;
    assign rf_wa = wa_q;
    assign rf_wd = wd_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; honours REGFILE_CLEAR_EN like the RTL.
module tb_regfile_write_arbiter;

`ifdef REGFILE_CLEAR_EN
    localparam logic CLEAR = 1'b1;
`else
    localparam logic CLEAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_addr  = '0;
    logic [31:0] req0_data  = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_addr  = '0;
    logic [31:0] req1_data  = '0;
    logic        req1_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        init_busy;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic r0, input logic r1, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.we = we; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    // Called just after a rising edge: ready is checked mid-cycle, the write after the next edge.
    task automatic step(input vec_t v, input int idx);
        drive(v.v0, v.a0, v.d0, v.v1, v.a1, v.d1);
        @(negedge clk);
        chk($sformatf("vec%0d req0_ready", idx), 32'(req0_ready), 32'(v.r0));
        chk($sformatf("vec%0d req1_ready", idx), 32'(req1_ready), 32'(v.r1));
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d rf_we", idx), 32'(rf_we), 32'(v.we));
        chk($sformatf("vec%0d rf_wa", idx), 32'(rf_wa), 32'(v.wa));
        chk($sformatf("vec%0d rf_wd", idx), rf_wd, v.wd);
        $display("vec %0d: v0=%0d a0=%0d v1=%0d a1=%0d -> rdy=%0d%0d we=%0d wa=%0d wd=0x%0h",
                 idx, v.v0, v.a0, v.v1, v.a1, req1_ready, req0_ready, rf_we, rf_wa, rf_wd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1, 5'd1,  32'h11,       1, 5'd2,  32'h22,   1, 0, 1, 5'd1,  32'h11);
        vecs[1]  = mk(1, 5'd1,  32'h11,       1, 5'd2,  32'h22,   0, 1, 1, 5'd2,  32'h22);
        vecs[2]  = mk(1, 5'd1,  32'h11,       1, 5'd2,  32'h22,   1, 0, 1, 5'd1,  32'h11);
        vecs[3]  = mk(1, 5'd1,  32'h11,       1, 5'd2,  32'h22,   0, 1, 1, 5'd2,  32'h22);
        vecs[4]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,    1, 0, 1, 5'd5,  32'hDEADBEEF);
        vecs[5]  = mk(0, 5'd0,  32'h0,        1, 5'd0,  32'h1234, 0, 1, 0, 5'd5,  32'hDEADBEEF);
        vecs[6]  = mk(1, 5'd3,  32'h33,       1, 5'd4,  32'h44,   1, 0, 1, 5'd3,  32'h33);
        vecs[7]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 0, 0, 5'd3,  32'h33);
        vecs[8]  = mk(0, 5'd0,  32'h0,        1, 5'd9,  32'h99,   0, 1, 1, 5'd9,  32'h99);
        vecs[9]  = mk(1, 5'd10, 32'hAA,       1, 5'd11, 32'hBB,   1, 0, 1, 5'd10, 32'hAA);
        vecs[10] = mk(1, 5'd31, 32'hFFFFFFFF, 0, 5'd0,  32'h0,    1, 0, 1, 5'd31, 32'hFFFFFFFF);

        // Reset state, with a request pending that must not be granted
        repeat (2) @(posedge clk);
        #1;
        chk("reset rf_we", 32'(rf_we), 32'd0);
        chk("reset rf_wa", 32'(rf_wa), 32'd0);
        chk("reset rf_wd", rf_wd, 32'd0);
        chk("reset init_busy", 32'(init_busy), 32'(CLEAR));
        req1_valid = 1'b1;
        req1_addr  = 5'd6;
        @(negedge clk);
        chk("reset req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        req1_valid = 1'b0;

`ifdef REGFILE_CLEAR_EN
        req0_valid = 1'b1;
        req0_addr  = 5'd9;
        @(negedge clk);
        chk("clr start init_busy", 32'(init_busy), 32'd1);
        chk("clr start rf_we", 32'(rf_we), 32'd0);
        chk("clr start req0_ready", 32'(req0_ready), 32'd0);
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("clr%0d rf_we", k), 32'(rf_we), 32'd1);
            chk($sformatf("clr%0d rf_wa", k), 32'(rf_wa), 32'(k));
            chk($sformatf("clr%0d rf_wd", k), rf_wd, 32'd0);
            chk($sformatf("clr%0d init_busy", k), 32'(init_busy), (k < 31) ? 32'd1 : 32'd0);
            $display("clear %0d: we=%0d wa=%0d busy=%0d", k, rf_we, rf_wa, init_busy);
            if (k < 31) begin
                @(negedge clk);
                chk($sformatf("clr%0d req0_ready", k), 32'(req0_ready), 32'd0);
            end
        end
        req0_valid = 1'b0;
`else
        @(negedge clk);
        chk("run init_busy", 32'(init_busy), 32'd0);
        @(posedge clk);
        #1;
        chk("idle after reset rf_we", 32'(rf_we), 32'd0);
`endif

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i], i);
        end

        // Idle: outputs hold, pointer (now 1) must survive
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle%0d rf_we", i), 32'(rf_we), 32'd0);
            chk($sformatf("idle%0d rf_wa", i), 32'(rf_wa), 32'd31);
        end
        chk("idle rf_wd", rf_wd, 32'hFFFFFFFF);
        drive(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
        @(negedge clk);
        chk("post-idle req0_ready", 32'(req0_ready), 32'd0);
        chk("post-idle req1_ready", 32'(req1_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("post-idle rf_wa", 32'(rf_wa), 32'd13);
        $display("post-idle: wa=%0d wd=0x%0h", rf_wa, rf_wd);

        // Reset the cycle after a grant to r7
        drive(1, 5'd7, 32'h77, 0, 5'd0, 32'h0);
        @(negedge clk);
        chk("r7 req0_ready", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("r7 rf_we", 32'(rf_we), 32'd1);
        chk("r7 rf_wa", 32'(rf_wa), 32'd7);
        rst       = 1'b1;
        req0_addr = 5'd8;
        @(negedge clk);
        chk("midrst req0_ready", 32'(req0_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst rf_we", 32'(rf_we), 32'd0);
        chk("midrst init_busy", 32'(init_busy), 32'(CLEAR));
        rst = 1'b0;
`ifdef REGFILE_CLEAR_EN
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("reclear rf_we", 32'(rf_we), 32'd1);
        chk("reclear rf_wa", 32'(rf_wa), 32'd0);
        chk("reclear init_busy", 32'(init_busy), 32'd1);
`else
        drive(1, 5'd14, 32'hE0, 1, 5'd15, 32'hF0);
        @(negedge clk);
        chk("after rst req0_ready", 32'(req0_ready), 32'd1);
        chk("after rst req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("after rst rf_wa", 32'(rf_wa), 32'd14);
`endif
        $display("reset mid-stream: we=%0d wa=%0d busy=%0d", rf_we, rf_wa, init_busy);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
